el2_ahb_arb2: RTL and testbench

- Two-master to one-slave AHB-Lite arbiter with per-master input holding stages.
- Lets the EL2 instruction-fetch port (M0) and LSU port (M1), both 64-bit AHB-Lite, share a single memory/peripheral bus.
- When the bus is busy or owned by the other master, a master's address phase is registered in a per-master holding register and issued later. The master's data phase is stretched with HREADY low until its transfer completes on the slave side.
- Sits between the core wrapper and the SoC bus fabric.

---
 rtl/el2_ahb_arb2.sv | 164 ++++++++++++++++
 tb/tb_el2_ahb_arb2.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/el2_ahb_arb2.sv
// Two-master to one-slave AHB-Lite arbiter for the EL2 fetch (M0) and LSU (M1) ports.
// A master that cannot be issued immediately has its address phase held and issued later.
module el2_ahb_arb2 #(
    parameter int AW       = 32,
    parameter int DW       = 64,
    parameter int ARB_MODE = 0
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic [AW-1:0] M0_HADDR,
    input  logic [1:0]    M0_HTRANS,
    input  logic          M0_HWRITE,
    input  logic [2:0]    M0_HSIZE,
    input  logic [2:0]    M0_HBURST,
    input  logic [3:0]    M0_HPROT,
    input  logic          M0_HMASTLOCK,
    input  logic [DW-1:0] M0_HWDATA,
    output logic [DW-1:0] M0_HRDATA,
    output logic          M0_HREADY,
    output logic          M0_HGRANT,
    input  logic [AW-1:0] M1_HADDR,
    input  logic [1:0]    M1_HTRANS,
    input  logic          M1_HWRITE,
    input  logic [2:0]    M1_HSIZE,
    input  logic [2:0]    M1_HBURST,
    input  logic [3:0]    M1_HPROT,
    input  logic          M1_HMASTLOCK,
    input  logic [DW-1:0] M1_HWDATA,
    output logic [DW-1:0] M1_HRDATA,
    output logic          M1_HREADY,
    output logic          M1_HGRANT,
    output logic [AW-1:0] S_HADDR,
    output logic [1:0]    S_HTRANS,
    output logic          S_HWRITE,
    output logic [2:0]    S_HSIZE,
    output logic [2:0]    S_HBURST,
    output logic [3:0]    S_HPROT,
    output logic          S_HMASTLOCK,
    output logic [DW-1:0] S_HWDATA,
    input  logic [DW-1:0] S_HRDATA,
    input  logic          S_HREADY
);

    // Address phase packed as {addr, trans, write, size, burst, prot, lock}; trans[1] is bit 13.
    localparam int PW = AW + 14;

    logic [1:0][PW-1:0] m_ap;
    logic [1:0][PW-1:0] pend_ap_q, pend_ap_d;
    logic [1:0]         pend_vld_q, pend_vld_d;
    logic               dvld_q, dvld_d;
    logic               downer_q, downer_d;
    logic               last_gnt_q, last_gnt_d;
    logic               lock_vld_q, lock_vld_d;
    logic               lock_own_q, lock_own_d;
    logic [1:0]         grant_q, grant_d;

    logic [1:0]         outst, hrdy, live, req, elig;
    logic               issue, win;
    logic [PW-1:0]      sel_ap, s_ap;

    assign m_ap[0] = {M0_HADDR, M0_HTRANS, M0_HWRITE, M0_HSIZE, M0_HBURST, M0_HPROT, M0_HMASTLOCK};
    assign m_ap[1] = {M1_HADDR, M1_HTRANS, M1_HWRITE, M1_HSIZE, M1_HBURST, M1_HPROT, M1_HMASTLOCK};

    always_comb begin
        outst = '0;
        hrdy  = '1;
        live  = '0;
        req   = '0;
        elig  = '0;
        for (int x = 0; x < 2; x++) begin
            outst[x] = pend_vld_q[x] | (dvld_q & (downer_q == x[0]));
            if (HRESETn && outst[x]) begin
                hrdy[x] = dvld_q & (downer_q == x[0]) & S_HREADY;
            end
            live[x] = HRESETn & m_ap[x][13] & hrdy[x];
            req[x]  = pend_vld_q[x] | live[x];
            elig[x] = req[x] & (~lock_vld_q | (lock_own_q == x[0]));
        end
    end

    always_comb begin
        issue = 1'b0;
        win   = 1'b0;
        if (HRESETn && S_HREADY) begin
            issue = |elig;
            if (ARB_MODE == 1) begin
                win = elig[1];
            end else begin
                unique case (elig)
                    2'b10:   win = 1'b1;
                    2'b11:   win = ~last_gnt_q;
                    default: win = 1'b0;
                endcase
            end
        end
        sel_ap = pend_vld_q[win] ? pend_ap_q[win] : m_ap[win];
        s_ap   = issue ? sel_ap : '0;
    end

    always_comb begin
        pend_ap_d  = pend_ap_q;
        pend_vld_d = pend_vld_q;
        dvld_d     = dvld_q;
        downer_d   = downer_q;
        last_gnt_d = last_gnt_q;
        lock_vld_d = lock_vld_q;
        lock_own_d = lock_own_q;
        grant_d    = grant_q;
        if (S_HREADY) begin
            if (issue) begin
                dvld_d     = 1'b1;
                downer_d   = win;
                last_gnt_d = win;
                grant_d    = win ? 2'b10 : 2'b01;
                lock_vld_d = sel_ap[0];
                lock_own_d = win;
            end else begin
                dvld_d     = 1'b0;
                lock_vld_d = 1'b0;
            end
        end
        // A live request never coexists with a pending one, so capture cannot overwrite.
        for (int x = 0; x < 2; x++) begin
            if (issue && (win == x[0])) begin
                pend_vld_d[x] = 1'b0;
            end else if (live[x]) begin
                pend_vld_d[x] = 1'b1;
                pend_ap_d[x]  = m_ap[x];
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            pend_ap_q  <= '0;
            pend_vld_q <= '0;
            dvld_q     <= 1'b0;
            downer_q   <= 1'b0;
            last_gnt_q <= 1'b1;
            lock_vld_q <= 1'b0;
            lock_own_q <= 1'b0;
            grant_q    <= '0;
        end else begin
            pend_ap_q  <= pend_ap_d;
            pend_vld_q <= pend_vld_d;
            dvld_q     <= dvld_d;
            downer_q   <= downer_d;
            last_gnt_q <= last_gnt_d;
            lock_vld_q <= lock_vld_d;
            lock_own_q <= lock_own_d;
            grant_q    <= grant_d;
        end
    end

    assign {S_HADDR, S_HTRANS, S_HWRITE, S_HSIZE, S_HBURST, S_HPROT, S_HMASTLOCK} = s_ap;
    assign S_HWDATA  = dvld_q ? (downer_q ? M1_HWDATA : M0_HWDATA) : '0;
    assign M0_HRDATA = S_HRDATA;
    assign M1_HRDATA = S_HRDATA;
    assign M0_HREADY = hrdy[0];
    assign M1_HREADY = hrdy[1];
    assign M0_HGRANT = grant_q[0] & HRESETn;
    assign M1_HGRANT = grant_q[1] & HRESETn;

endmodule

// File: tb/tb_el2_ahb_arb2.sv
// Directed cycle vectors for el2_ahb_arb2: round-robin instance u_rr, fixed-priority instance u_fp.
// Driver pushes each vector's expectations; a negedge monitor pops and compares.
module tb_el2_ahb_arb2;

    localparam logic [63:0] RDATA = 64'hDEADBEEF_CAFEF00D;
    localparam logic [63:0] WD0   = 64'hA0A0_0000_0000_00A0;
    localparam logic [63:0] WD1   = 64'hB1B1_0000_0000_00B1;

    typedef struct {
        int          id;
        logic        rstn, srdy;
        logic [1:0]  t0, t1;
        logic [31:0] a0, a1;
        logic        w0, w1, l0, l1;
        logic        c_rdy;  logic r0, r1;
        logic        c_s;    logic [1:0] st; logic [31:0] sa; logic sw; logic sl;
        logic        c_wd;   logic [63:0] swd;
        logic        c_g;    logic [1:0] g;
        logic        c_rd;
        logic        c_f;    logic fr0, fr1; logic [1:0] fst; logic [31:0] fsa;
    } vec_t;

    logic        HCLK, HRESETn, S_HREADY;
    logic [31:0] M0_HADDR, M1_HADDR;
    logic [1:0]  M0_HTRANS, M1_HTRANS;
    logic        M0_HWRITE, M1_HWRITE, M0_HMASTLOCK, M1_HMASTLOCK;
    logic [63:0] S_HRDATA;

    logic [63:0] r_rd0, r_rd1, r_wd, f_rd0, f_rd1, f_wd;
    logic        r_rdy0, r_rdy1, r_g0, r_g1, r_w, r_l, f_rdy0, f_rdy1, f_g0, f_g1, f_w, f_l;
    logic [31:0] r_a, f_a;
    logic [1:0]  r_t, f_t;
    logic [2:0]  r_sz, r_b, f_sz, f_b;
    logic [3:0]  r_p, f_p;

    vec_t q_exp[$];
    vec_t e, v;
    int   n_cmp = 0, n_mis = 0, n_vec = 0;

    el2_ahb_arb2 #(.AW(32), .DW(64), .ARB_MODE(0)) u_rr (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE), .M0_HSIZE(3'b011),
        .M0_HBURST(3'b000), .M0_HPROT(4'b0011), .M0_HMASTLOCK(M0_HMASTLOCK), .M0_HWDATA(WD0),
        .M0_HRDATA(r_rd0), .M0_HREADY(r_rdy0), .M0_HGRANT(r_g0),
        .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE), .M1_HSIZE(3'b011),
        .M1_HBURST(3'b000), .M1_HPROT(4'b0011), .M1_HMASTLOCK(M1_HMASTLOCK), .M1_HWDATA(WD1),
        .M1_HRDATA(r_rd1), .M1_HREADY(r_rdy1), .M1_HGRANT(r_g1),
        .S_HADDR(r_a), .S_HTRANS(r_t), .S_HWRITE(r_w), .S_HSIZE(r_sz), .S_HBURST(r_b),
        .S_HPROT(r_p), .S_HMASTLOCK(r_l), .S_HWDATA(r_wd), .S_HRDATA(S_HRDATA), .S_HREADY(S_HREADY)
    );

    el2_ahb_arb2 #(.AW(32), .DW(64), .ARB_MODE(1)) u_fp (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE), .M0_HSIZE(3'b011),
        .M0_HBURST(3'b000), .M0_HPROT(4'b0011), .M0_HMASTLOCK(M0_HMASTLOCK), .M0_HWDATA(WD0),
        .M0_HRDATA(f_rd0), .M0_HREADY(f_rdy0), .M0_HGRANT(f_g0),
        .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE), .M1_HSIZE(3'b011),
        .M1_HBURST(3'b000), .M1_HPROT(4'b0011), .M1_HMASTLOCK(M1_HMASTLOCK), .M1_HWDATA(WD1),
        .M1_HRDATA(f_rd1), .M1_HREADY(f_rdy1), .M1_HGRANT(f_g1),
        .S_HADDR(f_a), .S_HTRANS(f_t), .S_HWRITE(f_w), .S_HSIZE(f_sz), .S_HBURST(f_b),
        .S_HPROT(f_p), .S_HMASTLOCK(f_l), .S_HWDATA(f_wd), .S_HRDATA(S_HRDATA), .S_HREADY(S_HREADY)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    function automatic vec_t dflt();
        vec_t d;
        d = '{default: '0};
        d.rstn = 1'b1;
        d.srdy = 1'b1;
        return d;
    endfunction

    task automatic chk(input int id, input string f, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL v%0d %s: actual=%h required=%h", id, f, act, exp);
        end
    endtask

    task automatic apply(input vec_t x);
        @(posedge HCLK);
        #1;
        HRESETn   = x.rstn;
        S_HREADY  = x.srdy;
        M0_HTRANS = x.t0;  M0_HADDR = x.a0;  M0_HWRITE = x.w0;  M0_HMASTLOCK = x.l0;
        M1_HTRANS = x.t1;  M1_HADDR = x.a1;  M1_HWRITE = x.w1;  M1_HMASTLOCK = x.l1;
        n_vec++;
        x.id = n_vec;
        q_exp.push_back(x);
    endtask

    always @(negedge HCLK) begin
        if (q_exp.size() != 0) begin
            e = q_exp.pop_front();
            if (e.c_rdy) begin
                chk(e.id, "m0_hready", 64'(r_rdy0), 64'(e.r0));
                chk(e.id, "m1_hready", 64'(r_rdy1), 64'(e.r1));
            end
            if (e.c_s) begin
                chk(e.id, "s_htrans", 64'(r_t), 64'(e.st));
                chk(e.id, "s_hmastlock", 64'(r_l), 64'(e.sl));
                if (e.st == 2'b10) begin
                    chk(e.id, "s_haddr", 64'(r_a), 64'(e.sa));
                    chk(e.id, "s_hwrite", 64'(r_w), 64'(e.sw));
                end
            end
            if (e.c_wd) chk(e.id, "s_hwdata", r_wd, e.swd);
            if (e.c_g)  chk(e.id, "hgrant", 64'({r_g1, r_g0}), 64'(e.g));
            if (e.c_rd) begin
                chk(e.id, "m0_hrdata", r_rd0, RDATA);
                chk(e.id, "m1_hrdata", r_rd1, RDATA);
            end
            if (e.c_f) begin
                chk(e.id, "fp_m0_hready", 64'(f_rdy0), 64'(e.fr0));
                chk(e.id, "fp_m1_hready", 64'(f_rdy1), 64'(e.fr1));
                chk(e.id, "fp_s_htrans", 64'(f_t), 64'(e.fst));
                if (e.fst == 2'b10) chk(e.id, "fp_s_haddr", 64'(f_a), 64'(e.fsa));
            end
        end
    end

    initial begin
        S_HRDATA  = RDATA;
        HRESETn   = 1'b0;  S_HREADY = 1'b1;
        M0_HTRANS = 2'b10; M0_HADDR = 32'h100;  M0_HWRITE = 1'b0; M0_HMASTLOCK = 1'b0;
        M1_HTRANS = 2'b10; M1_HADDR = 32'h2000; M1_HWRITE = 1'b1; M1_HMASTLOCK = 1'b0;

        // Reset with both masters requesting.
        for (int i = 0; i < 2; i++) begin
            v = dflt(); v.rstn = 0; v.t0 = 2'b10; v.a0 = 32'h100; v.t1 = 2'b10; v.a1 = 32'h2000; v.w1 = 1;
            v.c_rdy = 1; v.r0 = 1; v.r1 = 1; v.c_s = 1; v.st = 0; v.c_g = 1; v.g = 0;
            apply(v);
        end

        // M0-only read, zero added latency.
        v = dflt(); v.t0 = 2'b10; v.a0 = 32'h100;
        v.c_rdy = 1; v.r0 = 1; v.r1 = 1; v.c_s = 1; v.st = 2'b10; v.sa = 32'h100; v.sw = 0; v.c_g = 1; v.g = 0;
        apply(v);
        v = dflt(); v.c_rdy = 1; v.r0 = 1; v.r1 = 1; v.c_s = 1; v.st = 0; v.c_rd = 1;
        v.c_wd = 1; v.swd = WD0; v.c_g = 1; v.g = 2'b01;
        apply(v);

        // Contention straight out of reset: M0 first, M1 write from its holding stage.
        v = dflt(); v.rstn = 0; v.c_g = 1; v.g = 0; apply(v);
        v = dflt(); v.t0 = 2'b10; v.a0 = 32'h100; v.t1 = 2'b10; v.a1 = 32'h2000; v.w1 = 1;
        v.c_rdy = 1; v.r0 = 1; v.r1 = 1; v.c_s = 1; v.st = 2'b10; v.sa = 32'h100; v.sw = 0;
        apply(v);
        v = dflt(); v.c_rdy = 1; v.r0 = 1; v.r1 = 0; v.c_s = 1; v.st = 2'b10; v.sa = 32'h2000; v.sw = 1;
        v.c_wd = 1; v.swd = WD0; v.c_g = 1; v.g = 2'b01;
        apply(v);
        v = dflt(); v.c_rdy = 1; v.r0 = 1; v.r1 = 1; v.c_s = 1; v.st = 0; v.c_wd = 1; v.swd = WD1;
        v.c_g = 1; v.g = 2'b10;
        apply(v);

        // Slave wait states while M1 is captured.
        v = dflt(); v.t0 = 2'b10; v.a0 = 32'h400;
        v.c_rdy = 1; v.r0 = 1; v.r1 = 1; v.c_s = 1; v.st = 2'b10; v.sa = 32'h400; v.sw = 0;
        apply(v);
        v = dflt(); v.srdy = 0; v.t1 = 2'b10; v.a1 = 32'h3000;
        v.c_rdy = 1; v.r0 = 0; v.r1 = 1; v.c_s = 1; v.st = 0;
        apply(v);
        for (int i = 0; i < 2; i++) begin
            v = dflt(); v.srdy = 0; v.c_rdy = 1; v.r0 = 0; v.r1 = 0; v.c_s = 1; v.st = 0;
            apply(v);
        end
        v = dflt(); v.c_rdy = 1; v.r0 = 1; v.r1 = 0; v.c_s = 1; v.st = 2'b10; v.sa = 32'h3000; v.sw = 0;
        v.c_rd = 1;
        apply(v);
        v = dflt(); v.c_rdy = 1; v.r0 = 1; v.r1 = 1; v.c_s = 1; v.st = 0; v.c_g = 1; v.g = 2'b10;
        apply(v);

        // Locked M1 pair holds off M0 until M1 goes idle.
        v = dflt(); v.t1 = 2'b10; v.a1 = 32'h600; v.w1 = 1; v.l1 = 1;
        v.c_s = 1; v.st = 2'b10; v.sa = 32'h600; v.sw = 1; v.sl = 1;
        apply(v);
        v = dflt(); v.t0 = 2'b10; v.a0 = 32'h500; v.t1 = 2'b10; v.a1 = 32'h608; v.w1 = 1; v.l1 = 1;
        v.c_rdy = 1; v.r0 = 1; v.r1 = 1; v.c_s = 1; v.st = 2'b10; v.sa = 32'h608; v.sw = 1; v.sl = 1;
        apply(v);
        v = dflt(); v.c_rdy = 1; v.r0 = 0; v.r1 = 1; v.c_s = 1; v.st = 0; v.sl = 0;
        apply(v);
        v = dflt(); v.c_rdy = 1; v.r0 = 0; v.r1 = 1; v.c_s = 1; v.st = 2'b10; v.sa = 32'h500; v.sw = 0; v.sl = 0;
        apply(v);
        v = dflt(); v.c_rdy = 1; v.r0 = 1; v.r1 = 1; v.c_s = 1; v.st = 0; v.c_g = 1; v.g = 2'b01;
        apply(v);

        // Fixed priority: M1 takes four slots, M0 waits in its holding stage.
        v = dflt(); v.rstn = 0; apply(v);
        v = dflt(); v.t0 = 2'b10; v.a0 = 32'h700; v.t1 = 2'b10; v.a1 = 32'h800;
        v.c_f = 1; v.fr0 = 1; v.fr1 = 1; v.fst = 2'b10; v.fsa = 32'h800;
        apply(v);
        for (int i = 1; i < 4; i++) begin
            v = dflt(); v.t1 = 2'b10; v.a1 = 32'h800 + 32'(8 * i);
            v.c_f = 1; v.fr0 = 0; v.fr1 = 1; v.fst = 2'b10; v.fsa = 32'h800 + 32'(8 * i);
            apply(v);
        end
        v = dflt(); v.c_f = 1; v.fr0 = 0; v.fr1 = 1; v.fst = 2'b10; v.fsa = 32'h700;
        apply(v);
        v = dflt(); v.c_f = 1; v.fr0 = 1; v.fr1 = 1; v.fst = 0;
        apply(v);

        for (int i = 0; i < 10 && q_exp.size() != 0; i++) @(posedge HCLK);
        if (q_exp.size() != 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL drain: actual=%0d required=0 vectors left unchecked", q_exp.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
